// File: rtl/dm_pkg.sv
// dm_pkg: store type codes and buffered store entry layout shared by the store buffer and its lane aligner
package dm_pkg;
  localparam logic [5:0] SW = 6'b000111;
  localparam logic [5:0] SH = 6'b010011;
  localparam logic [5:0] SB = 6'b010100;
  typedef struct packed {
    logic [29:0] word_addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dm_st_entry_t;
endpackage

// File: rtl/dm_store_align.sv
// dm_store_align: combinational lane encoder (st_type, addr[1:0], data -> be, wdata, misaligned); unknown types encode be=0000
module dm_store_align
  import dm_pkg::*;
(
  input  logic [5:0]  st_type,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned
);
  always_comb begin
    misaligned = (st_type == SW && addr != 2'b00) || (st_type == SH && addr[0]);
    be = st_type == SW ? 4'b1111 :
         st_type == SH ? (addr[1] ? 4'b1100 : 4'b0011) :
         st_type == SB ? 4'b0001 << addr :
         4'b0000;
    wdata = st_type == SW ? data :
            st_type == SH ? (addr[1] ? {data[15:0], 16'b0} : {16'b0, data[15:0]}) :
            st_type == SB ? {4{data[7:0]}} :
            32'b0;
  end
endmodule

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: in-order store FIFO (MEM-stage push, data-memory drain, word-granular load hit); define DM_STORE_MISALIGN_EXC_EN to trap misaligned SW/SH on the misalign port instead of enqueueing them
module dm_store_buffer
  import dm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [5:0]  st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
`ifdef DM_STORE_MISALIGN_EXC_EN
  output logic        empty,
  output logic        misalign
`else
  output logic        empty
`endif
);
  localparam int AW = $clog2(DEPTH);
`ifdef DM_STORE_MISALIGN_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif
  dm_st_entry_t ent [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  logic [3:0] be;
  logic [31:0] wdata;
  logic mis, acc, push, pop;
  logic unused_ld;
  dm_store_align u_align (
    .st_type(st_type),
    .addr(st_addr[1:0]),
    .data(st_data),
    .be(be),
    .wdata(wdata),
    .misaligned(mis)
  );
  assign empty = count == '0;
  assign st_ready = count != (AW+1)'(DEPTH);
  assign mem_valid = !empty;
  assign acc = st_valid && st_ready;
  assign push = acc && !(EXC_EN && mis);
  assign pop = mem_valid && mem_ready;
  assign mem_addr = {ent[head].word_addr, 2'b00};
  assign mem_be = ent[head].be;
  assign mem_wdata = ent[head].wdata;
  assign unused_ld = ^ld_addr[1:0];
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      ld_hit = ld_hit | (vld[i] && ent[i].word_addr == ld_addr[31:2]);
  end
  always_ff @(posedge clk)
    if (push) ent[tail] <= '{word_addr: st_addr[31:2], be: be, wdata: wdata};
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      vld <= '0;
    end else begin
      if (push) begin
        vld[tail] <= 1'b1;
        tail <= tail + 1'b1;
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head <= head + 1'b1;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
`ifdef DM_STORE_MISALIGN_EXC_EN
  always_ff @(posedge clk)
    misalign <= reset ? 1'b0 : acc && mis;
`endif
endmodule

// File: tb/tb_dm_store_buffer.sv
// tb_dm_store_buffer: directed plus randomized checks of dm_store_buffer against a queue-based store model
module tb_dm_store_buffer;
  localparam logic [5:0] T_SW = 6'b000111;
  localparam logic [5:0] T_SH = 6'b010011;
  localparam logic [5:0] T_SB = 6'b010100;
  localparam logic [5:0] T_XX = 6'b111111;
  logic clk = 1'b0, reset = 1'b1, st_valid = 1'b0, mem_ready = 1'b0;
  logic [5:0] st_type = '0;
  logic [31:0] st_addr = '0, st_data = '0, ld_addr = '0;
  logic st_ready, mem_valid, ld_hit, empty;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_be;
`ifdef DM_STORE_MISALIGN_EXC_EN
  logic misalign;
  bit exp_mis = 1'b0;
`endif
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } ent_t;
  ent_t q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dm_store_buffer #(.DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .st_valid(st_valid),
    .st_ready(st_ready),
    .st_type(st_type),
    .st_addr(st_addr),
    .st_data(st_data),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be(mem_be),
    .ld_addr(ld_addr),
    .ld_hit(ld_hit),
`ifdef DM_STORE_MISALIGN_EXC_EN
    .empty(empty),
    .misalign(misalign)
`else
    .empty(empty)
`endif
  );
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic ent_t encode(logic [5:0] ty, logic [31:0] a, logic [31:0] d);
    ent_t e;
    int off;
    e.addr = a & ~32'h3;
    e.be = 4'h0;
    e.wdata = 32'h0;
    off = int'(a % 4);
    if (ty == T_SW) begin
      e.be = 4'hf;
      e.wdata = d;
    end else if (ty == T_SH) begin
      off = (off / 2) * 2;
      e.be = 4'(3 << off);
      e.wdata = (d & 32'hffff) << (8 * off);
    end else if (ty == T_SB) begin
      e.be = 4'(1 << off);
      e.wdata = (d & 32'hff) * 32'h01010101;
    end
    return e;
  endfunction
  function automatic bit misal(logic [5:0] ty, logic [31:0] a);
    return (ty == T_SW && a % 4 != 0) || (ty == T_SH && a % 2 != 0);
  endfunction
  task automatic check_outputs();
    bit hit;
    hit = 1'b0;
    foreach (q[i]) if ((q[i].addr >> 2) == (ld_addr >> 2)) hit = 1'b1;
    chk("st_ready", 32'(st_ready), 32'(q.size() < 4));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
    chk("ld_hit", 32'(ld_hit), 32'(hit));
    if (q.size() > 0) begin
      chk("mem_addr", mem_addr, q[0].addr);
      chk("mem_be", 32'(mem_be), 32'(q[0].be));
      if (q[0].be != 4'h0) chk("mem_wdata", mem_wdata, q[0].wdata);
    end
`ifdef DM_STORE_MISALIGN_EXC_EN
    chk("misalign", 32'(misalign), 32'(exp_mis));
`endif
  endtask
  task automatic cycle(bit sv, logic [5:0] ty, logic [31:0] a, logic [31:0] d, bit mr, logic [31:0] la, bit rs);
    bit acc, pop;
    ent_t e;
    @(negedge clk);
    st_valid = sv;
    st_type = ty;
    st_addr = a;
    st_data = d;
    mem_ready = mr;
    ld_addr = la;
    reset = rs;
    #1;
    check_outputs();
    acc = sv && q.size() < 4;
    pop = q.size() > 0 && mr;
    e = encode(ty, a, d);
    @(posedge clk);
    if (rs) begin
      q.delete();
`ifdef DM_STORE_MISALIGN_EXC_EN
      exp_mis = 1'b0;
`endif
    end else begin
      if (pop) q.delete(0);
`ifdef DM_STORE_MISALIGN_EXC_EN
      if (acc && !misal(ty, a)) q.push_back(e);
      exp_mis = acc && misal(ty, a);
`else
      if (acc) q.push_back(e);
`endif
    end
  endtask
  task automatic idle(bit mr);
    cycle(1'b0, T_SW, 32'h0, 32'h0, mr, 32'hffff_fff0, 1'b0);
  endtask
  initial begin
    logic [5:0] types [4];
    types = '{T_SW, T_SH, T_SB, T_XX};
    repeat (2) @(posedge clk);
    idle(1'b0);
    cycle(1'b1, T_SB, 32'h104, 32'h0000_00ab, 1'b0, 32'h0, 1'b0);
    #1;
    chk("sb_visible", 32'(mem_valid), 32'h1);
    chk("sb_addr", mem_addr, 32'h104);
    chk("sb_be", 32'(mem_be), 32'h1);
    chk("sb_wdata", mem_wdata, 32'habab_abab);
    idle(1'b1);
    cycle(1'b1, T_SH, 32'h202, 32'h0000_1234, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, T_SW, 32'h300, 32'hdead_beef, 1'b0, 32'h0, 1'b0);
    #1;
    chk("sh_be", 32'(mem_be), 32'hc);
    chk("sh_wdata", mem_wdata, 32'h1234_0000);
    idle(1'b1);
    #1;
    chk("sw_be", 32'(mem_be), 32'hf);
    chk("sw_wdata", mem_wdata, 32'hdead_beef);
    idle(1'b1);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, T_SW, 32'h500 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 32'h0, 1'b0);
    #1;
    chk("full_ready", 32'(st_ready), 32'h0);
    cycle(1'b1, T_SW, 32'h510, 32'h1004, 1'b1, 32'h0, 1'b0);
    #1;
    chk("full_push_rejected", 32'(q.size()), 32'h3);
    for (int i = 0; i < 5; i++)
      cycle(i == 0, T_SW, 32'h510, 32'h1004, 1'b1, 32'h0, 1'b0);
    idle(1'b1);
    cycle(1'b1, T_SW, 32'h400, 32'h55, 1'b0, 32'h403, 1'b0);
    #1;
    chk("hit_403", 32'(ld_hit), 32'h1);
    cycle(1'b0, T_SW, 32'h0, 32'h0, 1'b0, 32'h404, 1'b0);
    cycle(1'b0, T_SW, 32'h0, 32'h0, 1'b1, 32'h400, 1'b0);
    #1;
    chk("hit_after_retire", 32'(ld_hit), 32'h0);
    cycle(1'b1, T_SW, 32'h101, 32'h77, 1'b0, 32'h100, 1'b0);
`ifdef DM_STORE_MISALIGN_EXC_EN
    #1;
    chk("mis_pulse", 32'(misalign), 32'h1);
    chk("mis_empty", 32'(empty), 32'h1);
    idle(1'b0);
    #1;
    chk("mis_one_cycle", 32'(misalign), 32'h0);
`endif
    idle(1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, T_SB, 32'h600 + 32'(i), 32'h20 + 32'(i), 1'b0, 32'h0, 1'b0);
    cycle(1'b1, T_SW, 32'h700, 32'h1, 1'b1, 32'h0, 1'b1);
    #1;
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_mem_valid", 32'(mem_valid), 32'h0);
    idle(1'b0);
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), types[$urandom_range(0, 3)],
            32'h400 + 32'($urandom_range(0, 15)) + 32'($urandom_range(0, 1) << 8),
            $urandom, 1'($urandom_range(0, 2) == 0),
            32'h400 + 32'($urandom_range(0, 15)) + 32'($urandom_range(0, 1) << 8), 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
